// File: rtl/cache_fill_if.sv
// Signal bundle between the fill controller, the two cache fill ports and main memory.
// master = the controller side, slave = the caches/memory/pipeline side.
interface cache_fill_if #(
  parameter int unsigned AddrW = 16
);
  logic             i_miss;
  logic [AddrW-1:0] i_miss_addr;
  logic             d_miss;
  logic [AddrW-1:0] d_miss_addr;
  logic             mem_enable;
  logic [AddrW-1:0] mem_addr;
  logic             mem_data_valid;
  logic [AddrW-1:0] mem_data_out;
  logic [AddrW-1:0] fill_addr;
  logic [AddrW-1:0] fill_data;
  logic             i_load_data;
  logic             i_load_tag;
  logic             d_load_data;
  logic             d_load_tag;
  logic             i_stall;
  logic             d_stall;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data_out,
    output mem_enable, mem_addr, fill_addr, fill_data,
    output i_load_data, i_load_tag, d_load_data, d_load_tag, i_stall, d_stall
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data_out,
    input  mem_enable, mem_addr, fill_addr, fill_data,
    input  i_load_data, i_load_tag, d_load_data, d_load_tag, i_stall, d_stall
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss handler arbitrating I/D cache block fills from pipelined memory; D side has priority.
// Issues one read per cycle for the block and streams returns into the selected cache.
module cache_fill_ctrl #(
  parameter int unsigned BlockWords = 8,
  parameter int unsigned AddrW      = 16
) (
  input logic          clk_i,
  input logic          rst_ni,
  cache_fill_if.master bus
);

  localparam int unsigned OffW     = $clog2(BlockWords);
  localparam int unsigned ByteOffW = OffW + 1;
  localparam logic [OffW-1:0] LastIdx = OffW'(BlockWords - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e           state_q, state_d;
  logic             sel_d_q, sel_d_d;  // 1: D-cache is being filled, 0: I-cache
  logic [OffW-1:0]  issue_cnt_q, issue_cnt_d;
  logic             issue_done_q, issue_done_d;
  logic [OffW-1:0]  recv_cnt_q, recv_cnt_d;
  logic [AddrW-1:0] base_q, base_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      sel_d_q      <= 1'b0;
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      recv_cnt_q   <= '0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      sel_d_q      <= sel_d_d;
      issue_cnt_q  <= issue_cnt_d;
      issue_done_q <= issue_done_d;
      recv_cnt_q   <= recv_cnt_d;
      base_q       <= base_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d_d      = sel_d_q;
    issue_cnt_d  = issue_cnt_q;
    issue_done_d = issue_done_q;
    recv_cnt_d   = recv_cnt_q;
    base_d       = base_q;
    unique case (state_q)
      StIdle: begin
        issue_cnt_d  = '0;
        issue_done_d = 1'b0;
        recv_cnt_d   = '0;
        if (bus.d_miss) begin
          sel_d_d                 = 1'b1;
          base_d                  = bus.d_miss_addr;
          base_d[ByteOffW-1:0]    = '0;
          state_d                 = StFill;
        end else if (bus.i_miss) begin
          sel_d_d                 = 1'b0;
          base_d                  = bus.i_miss_addr;
          base_d[ByteOffW-1:0]    = '0;
          state_d                 = StFill;
        end
      end
      StFill: begin
        // The counter wraps, so a separate flag keeps the issue side quiet after the last word.
        if (!issue_done_q) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LastIdx) begin
            issue_done_d = 1'b1;
          end
        end
        if (bus.mem_data_valid) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LastIdx) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  logic load_en;
  logic tag_en;

  always_comb begin
    bus.mem_enable  = 1'b0;
    bus.mem_addr    = '0;
    bus.fill_addr   = '0;
    bus.fill_data   = '0;
    load_en         = 1'b0;
    tag_en          = 1'b0;
    if (state_q == StFill) begin
      if (!issue_done_q) begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = base_q + AddrW'({issue_cnt_q, 1'b0});
      end
      if (bus.mem_data_valid) begin
        load_en       = 1'b1;
        tag_en        = (recv_cnt_q == LastIdx);
        bus.fill_addr = base_q + AddrW'({recv_cnt_q, 1'b0});
        bus.fill_data = bus.mem_data_out;
      end
    end
    bus.d_load_data = load_en & sel_d_q;
    bus.d_load_tag  = tag_en & sel_d_q;
    bus.i_load_data = load_en & ~sel_d_q;
    bus.i_load_tag  = tag_en & ~sel_d_q;
    // Gated by reset so every output reads 0 while reset is held, even with a miss pending.
    bus.i_stall = rst_ni & (bus.i_miss | ((state_q == StFill) & ~sel_d_q));
    bus.d_stall = rst_ni & (bus.d_miss | ((state_q == StFill) & sel_d_q));
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a 4-cycle pipelined memory returning addr^A5A5.
module tb_cache_fill_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic stray_v = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  cache_fill_if #(.AddrW(16)) bus ();

  cache_fill_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Memory model: request seen in cycle c returns in cycle c+4.
  logic [3:0]  pv = 4'b0;
  logic [15:0] pa0 = 16'h0, pa1 = 16'h0, pa2 = 16'h0, pa3 = 16'h0;
  always @(posedge clk) begin
    pv  <= {pv[2:0], bus.mem_enable};
    pa0 <= bus.mem_addr;
    pa1 <= pa0;
    pa2 <= pa1;
    pa3 <= pa2;
  end
  assign bus.mem_data_valid = pv[3] | stray_v;
  assign bus.mem_data_out   = stray_v ? 16'hDEAD : (pv[3] ? (pa3 ^ 16'hA5A5) : 16'h0);

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag, input logic exp_istall, input logic exp_dstall);
    check_eq({tag, " mem_enable"}, {15'h0, bus.mem_enable}, 16'h0);
    check_eq({tag, " mem_addr"}, bus.mem_addr, 16'h0);
    check_eq({tag, " fill_addr"}, bus.fill_addr, 16'h0);
    check_eq({tag, " fill_data"}, bus.fill_data, 16'h0);
    check_eq({tag, " loads"}, {12'h0, bus.i_load_data, bus.i_load_tag, bus.d_load_data,
                               bus.d_load_tag}, 16'h0);
    check_eq({tag, " i_stall"}, {15'h0, bus.i_stall}, {15'h0, exp_istall});
    check_eq({tag, " d_stall"}, {15'h0, bus.d_stall}, {15'h0, exp_dstall});
  endtask

  // Called at cycle 0 with the miss already driven; returns sampled in the DONE cycle (13).
  task automatic chk_fill(input bit sel_d, input logic [15:0] base, input int drop_cyc,
                          input bit other_miss);
    logic        exp_en, exp_ld, exp_tag, miss_now;
    logic [15:0] exp_ma, exp_fa, exp_fd;
    logic        got_ld, got_tag, got_stall, other_stall;
    logic [1:0]  got_other;
    string       t;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      step();
      t        = $sformatf("%s@%h c%0d", sel_d ? "D" : "I", base, cyc);
      exp_en   = (cyc <= 8);
      exp_ma   = exp_en ? base + 16'(2 * (cyc - 1)) : 16'h0;
      exp_ld   = (cyc >= 5) && (cyc <= 12);
      exp_fa   = exp_ld ? base + 16'(2 * (cyc - 5)) : 16'h0;
      exp_fd   = exp_ld ? (exp_fa ^ 16'hA5A5) : 16'h0;
      exp_tag  = (cyc == 12);
      miss_now = (cyc <= drop_cyc);
      got_ld      = sel_d ? bus.d_load_data : bus.i_load_data;
      got_tag     = sel_d ? bus.d_load_tag : bus.i_load_tag;
      got_stall   = sel_d ? bus.d_stall : bus.i_stall;
      other_stall = sel_d ? bus.i_stall : bus.d_stall;
      got_other   = sel_d ? {bus.i_load_data, bus.i_load_tag}
                          : {bus.d_load_data, bus.d_load_tag};
      check_eq({t, " mem_enable"}, {15'h0, bus.mem_enable}, {15'h0, exp_en});
      check_eq({t, " mem_addr"}, bus.mem_addr, exp_ma);
      check_eq({t, " load_data"}, {15'h0, got_ld}, {15'h0, exp_ld});
      check_eq({t, " load_tag"}, {15'h0, got_tag}, {15'h0, exp_tag});
      check_eq({t, " fill_addr"}, bus.fill_addr, exp_fa);
      check_eq({t, " fill_data"}, bus.fill_data, exp_fd);
      check_eq({t, " other_loads"}, {14'h0, got_other}, 16'h0);
      check_eq({t, " stall"}, {15'h0, got_stall}, {15'h0, (miss_now || cyc <= 12)});
      check_eq({t, " other_stall"}, {15'h0, other_stall}, {15'h0, other_miss});
      if (cyc == drop_cyc) begin
        if (sel_d) bus.d_miss = 1'b0;
        else       bus.i_miss = 1'b0;
      end
    end
  endtask

  initial begin
    bus.i_miss      = 1'b0;
    bus.i_miss_addr = 16'h0;
    bus.d_miss      = 1'b0;
    bus.d_miss_addr = 16'h0;
    #1 rst_n = 1'b0;
    #1 check_quiet("reset", 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Stray memory return while idle must be ignored.
    step();
    stray_v = 1'b1;
    #1 check_quiet("stray", 1'b0, 1'b0);
    step();
    stray_v = 1'b0;
    check_quiet("stray_after", 1'b0, 1'b0);

    // Single D miss at 0x0608.
    bus.d_miss_addr = 16'h0608;
    bus.d_miss      = 1'b1;
    chk_fill(1'b1, 16'h0600, 12, 1'b0);
    step();
    check_quiet("d_idle", 1'b0, 1'b0);

    // Simultaneous misses: D first, then I.
    bus.i_miss_addr = 16'h1234;
    bus.i_miss      = 1'b1;
    bus.d_miss_addr = 16'h8000;
    bus.d_miss      = 1'b1;
    chk_fill(1'b1, 16'h8000, 12, 1'b1);
    step();
    check_quiet("both_idle", 1'b1, 1'b0);
    chk_fill(1'b0, 16'h1230, 12, 1'b0);
    step();
    check_quiet("both_end", 1'b0, 1'b0);

    // D miss dropped early; fill still completes, address change ignored.
    bus.d_miss_addr = 16'h4A3C;
    bus.d_miss      = 1'b1;
    fork
      begin
        step();
        bus.d_miss_addr = 16'hFFFF;
      end
    join_none
    chk_fill(1'b1, 16'h4A30, 3, 1'b0);
    step();
    check_quiet("drop_idle", 1'b0, 1'b0);

    // Back-to-back I misses with a single DONE cycle between fills.
    bus.i_miss_addr = 16'h0010;
    bus.i_miss      = 1'b1;
    chk_fill(1'b0, 16'h0010, 12, 1'b0);
    bus.i_miss_addr = 16'h0020;
    bus.i_miss      = 1'b1;
    step();
    check_quiet("b2b_idle", 1'b1, 1'b0);
    chk_fill(1'b0, 16'h0020, 12, 1'b0);
    step();
    check_quiet("b2b_end", 1'b0, 1'b0);

    // Reset in the middle of a D fill; in-flight returns are not forwarded.
    bus.d_miss_addr = 16'h0608;
    bus.d_miss      = 1'b1;
    for (int c = 1; c <= 6; c++) step();
    check_eq("pre_rst d_load_data", {15'h0, bus.d_load_data}, 16'h1);
    rst_n = 1'b0;
    #1 check_quiet("rst_mid", 1'b0, 1'b0);
    bus.d_miss = 1'b0;
    step();
    check_quiet("rst_hold", 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check_quiet($sformatf("post_rst c%0d", c), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
